// File: rtl/activity_pkg.sv
// Shared types and default widths for the activity-bank enable sequencer.
// The FSM state encoding is also what the sequencer exposes on its debug port.
package activity_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

   localparam int DEF_BANKS = 4;
   localparam int DEF_ON_W  = 16;
   localparam int DEF_OFF_W = 16;
   localparam int DEF_NB_W  = 8;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/activity_down_counter.sv
// Loadable down-counter that saturates at zero.
// Loading period-1 makes "zero" mark the final cycle of a period.
module activity_down_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] value,
   input  logic         en,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (en && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/activity_sequencer.sv
// Emits a programmed train of enable bursts to the activity banks, with a trigger
// pulse on each burst onset. Every output is a flop so activity_en cannot glitch.
module activity_sequencer
   import activity_pkg::*;
#(
   parameter int G_BANKS = DEF_BANKS,
   parameter int G_ON_W  = DEF_ON_W,
   parameter int G_OFF_W = DEF_OFF_W,
   parameter int G_NB_W  = DEF_NB_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [G_ON_W-1:0]  on_cycles,
   input  logic [G_OFF_W-1:0] off_cycles,
   input  logic [G_NB_W-1:0]  num_bursts,
   input  logic [G_BANKS-1:0] bank_mask,
   output logic [G_BANKS-1:0] activity_en,
   output logic               trig,
   output logic               busy,
   output logic               done,
   output logic [G_NB_W-1:0]  burst_idx,
   output logic [1:0]         state_dbg
);

   localparam int PW = max_int(G_ON_W, G_OFF_W);

   // start is a one-cycle command honoured only in IDLE with abort low; it is
   // never queued. abort is a level that wins over every other transition.

   state_t               state_q, state_d;
   logic [G_ON_W-1:0]    on_q;
   logic [G_OFF_W-1:0]   off_q;
   logic [G_BANKS-1:0]   mask_q;
   logic                 latch;

   logic [G_BANKS-1:0]   en_d;
   logic                 trig_d, busy_d, done_d;
   logic [G_NB_W-1:0]    idx_d;

   logic                 pc_load, pc_en, pc_zero;
   logic [PW-1:0]        pc_value;
   logic                 bc_load, bc_en, bc_zero;
   logic [G_NB_W-1:0]    bc_value;

   logic [PW-1:0]        on_in_ld, on_q_ld, off_q_ld;

   // An ON length of zero behaves as one cycle.
   assign on_in_ld = (on_cycles == '0) ? '0 : PW'(on_cycles - 1'b1);
   assign on_q_ld  = (on_q == '0)      ? '0 : PW'(on_q - 1'b1);
   assign off_q_ld = PW'(off_q - 1'b1);

   activity_down_counter #(.W(PW)) u_period_cnt (
      .clk   (clk),
      .rst   (rst),
      .load  (pc_load),
      .value (pc_value),
      .en    (pc_en),
      .zero  (pc_zero)
   );

   // Holds the number of bursts still to start; zero means the current one is last.
   activity_down_counter #(.W(G_NB_W)) u_burst_cnt (
      .clk   (clk),
      .rst   (rst),
      .load  (bc_load),
      .value (bc_value),
      .en    (bc_en),
      .zero  (bc_zero)
   );

   always_comb begin
      state_d  = state_q;
      latch    = 1'b0;
      en_d     = '0;
      trig_d   = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      idx_d    = burst_idx;
      pc_load  = 1'b0;
      pc_en    = 1'b0;
      pc_value = '0;
      bc_load  = 1'b0;
      bc_en    = 1'b0;
      bc_value = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               latch  = 1'b1;
               busy_d = 1'b1;
               if (num_bursts == '0) begin
                  state_d = ST_FIN;
                  done_d  = 1'b1;
               end else begin
                  state_d  = ST_ON;
                  en_d     = bank_mask;
                  trig_d   = 1'b1;
                  idx_d    = '0;
                  pc_load  = 1'b1;
                  pc_value = on_in_ld;
                  bc_load  = 1'b1;
                  bc_value = num_bursts - 1'b1;
               end
            end
         end
         ST_ON: begin
            busy_d = 1'b1;
            if (!pc_zero) begin
               en_d  = mask_q;
               pc_en = 1'b1;
            end else if (bc_zero) begin
               state_d = ST_FIN;
               done_d  = 1'b1;
            end else if (off_q != '0) begin
               state_d  = ST_OFF;
               pc_load  = 1'b1;
               pc_value = off_q_ld;
            end else begin
               // Back-to-back bursts: enables stay high, trig marks the new onset.
               en_d     = mask_q;
               trig_d   = 1'b1;
               idx_d    = burst_idx + 1'b1;
               pc_load  = 1'b1;
               pc_value = on_q_ld;
               bc_en    = 1'b1;
            end
         end
         ST_OFF: begin
            busy_d = 1'b1;
            if (!pc_zero) begin
               pc_en = 1'b1;
            end else begin
               state_d  = ST_ON;
               en_d     = mask_q;
               trig_d   = 1'b1;
               idx_d    = burst_idx + 1'b1;
               pc_load  = 1'b1;
               pc_value = on_q_ld;
               bc_en    = 1'b1;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (abort && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         en_d    = '0;
         trig_d  = 1'b0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         idx_d   = burst_idx;
         pc_load = 1'b0;
         pc_en   = 1'b0;
         bc_en   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         activity_en <= '0;
         trig        <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         burst_idx   <= '0;
         on_q        <= '0;
         off_q       <= '0;
         mask_q      <= '0;
      end else begin
         state_q     <= state_d;
         activity_en <= en_d;
         trig        <= trig_d;
         busy        <= busy_d;
         done        <= done_d;
         burst_idx   <= idx_d;
         if (latch) begin
            on_q   <= on_cycles;
            off_q  <= off_cycles;
            mask_q <= bank_mask;
         end
      end
   end

   assign state_dbg = state_q;

endmodule

// File: doc/activity_sequencer.md
# activity_sequencer

Synchronous controller that drives the `activity_en` inputs of the ring-oscillator activity banks. On a start command it emits a programmed train of enable bursts (ON/OFF periods, burst count, bank mask), along with a trigger pulse aligned to each burst onset for the TDC capture logic. It sits between the host/config registers and the activity banks, and is the only source of their enables.

## Interface
- `G_BANKS`, 4: number of independent activity banks, one enable bit each.
- `G_ON_W`, 16: width of ON-period count.
- `G_OFF_W`, 16: width of OFF-period count.
- `G_NB_W`, 8: width of burst count.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle command; accepted only in IDLE.
- `abort`  in  1  level; forces all enables low and returns to IDLE.
- `on_cycles`  in  G_ON_W  ON length per burst, in clk cycles.
- `off_cycles`  in  G_OFF_W  OFF gap between bursts, in clk cycles.
- `num_bursts`  in  G_NB_W  number of bursts.
- `bank_mask`  in  G_BANKS  banks enabled during ON.
- `activity_en`  out  G_BANKS  registered enables to the activity banks.
- `trig`  out  1  one-cycle pulse on the first ON cycle of each burst.
- `busy`  out  1  high from the cycle after `start` acceptance until return to IDLE.
- `done`  out  1  one-cycle pulse on normal completion.
- `burst_idx`  out  G_NB_W  index of the current burst, 0-based.

## Operation
- States: IDLE, ON, OFF, FIN.
- IDLE + `start`: latch `on_cycles`, `off_cycles`, `num_bursts` and `bank_mask`. Later input changes are ignored until the next IDLE.
  - If latched `num_bursts`==0, go to FIN.
  - Otherwise go to ON with `burst_idx`=0.
- ON: `activity_en`=latched mask. Stay for max(on_cycles,1) cycles; `on_cycles`=0 is treated as 1.
  - At the end, if `burst_idx`==num_bursts-1, go to FIN.
  - Otherwise go to OFF if `off_cycles`>0. If `off_cycles`==0, go straight to ON with `burst_idx`+1, and `activity_en` stays high across the boundary.
- OFF: `activity_en`=0 for `off_cycles` cycles, then go to ON with `burst_idx`+1.
- FIN: `activity_en`=0, `done`=1 for one cycle, then IDLE.
- `trig`=1 on the first cycle of every ON state. This includes back-to-back ON states when `off_cycles`==0.
- `abort` (any non-IDLE state): next cycle `activity_en`=0 and state is IDLE. No `done`. Abort has priority over all transitions. `start` is ignored while `abort` is high.
- `start` in a non-IDLE state is ignored, not queued.
- Counters are down-counters loaded with the period minus 1; a period ends when the count reaches 0. There is no wrap-around: the max period is 2^W-1 cycles, and `on_cycles`=2^G_ON_W-1 must work.
- Reset values: `activity_en`=0, `trig`=0, `busy`=0, `done`=0, `burst_idx`=0, state IDLE. `rst` mid-burst drops enables on the next edge.
- All outputs are flop outputs. There is no combinational path from inputs to `activity_en`, which prevents glitches that would start the oscillator loops spuriously.

## Timing
- `start` sampled high at edge T → `activity_en`, `trig` and `busy` high from T+1.
- Burst k ON window = cycles [T+1+k·(ON+OFF), T+k·(ON+OFF)+ON], using effective ON.
- The last ON window is followed by exactly one FIN cycle: `done`=1, `busy`=1, `activity_en`=0. `busy` falls on the next cycle.
- Total busy length = N·ON + (N-1)·OFF + 1 cycles. With N=0 it is 1 cycle (FIN only).
- `burst_idx` updates on the same edge as entry into each new ON state.
- A new `start` is accepted in the cycle after `done`. That cycle is IDLE.

## Structure
- Package `activity_pkg`: state enum (IDLE/ON/OFF/FIN) and default width constants for G_ON_W/G_OFF_W/G_NB_W.
- One sub-module `activity_down_counter`: parameterised width, with load/value/enable inputs and a `zero` flag. It is instantiated twice, once for the ON/OFF period and once for burst count. `burst_idx` is a separate up-counter in the top level.

## Test plan
- Reset: assert `rst` 3 cycles mid-burst → next edge `activity_en`=0, `busy`=0, `burst_idx`=0, state IDLE.
- on=3, off=2, N=2, mask=4'b1011, start at T → en=1011 on T+1..T+3 and T+6..T+8, `trig` at T+1 and T+6, `done` at T+9, `busy` low at T+10.
- off=0, on=2, N=3 → en continuously high for 6 cycles, `trig` at offsets +1, +3, +5, `burst_idx` 0→1→2.
- N=0 → `busy` and `done` high for exactly one cycle at T+1, `activity_en` never asserted, `trig` never pulses. on=0, N=1 → one ON cycle.
- `abort` on 2nd cycle of OFF in a 4-burst run → next edge enables 0, IDLE, no `done`. Next `start` replays from `burst_idx`=0 with freshly latched config.
- `start` re-pulsed and `on_cycles` changed while busy → no effect on the current sequence. Timing matches the config latched at the original start.
